// File: rtl/mmio_map_bridge_if.sv
// Host MMIO request/response channel and FPU mapped-data port of mmio_map_bridge.
interface mmio_map_bridge_if;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        mmio_rsp_valid;
    logic [8:0]  mmio_rsp_tid;
    logic [63:0] mmio_rsp_data;
    logic        mapped_stall;
    logic        mapped_data_valid;
    logic [31:0] mapped_data;
    logic [31:0] mapped_address;
    logic        fifo_overflow;

    // Host / FPU side: issues MMIO traffic and back-pressure, observes responses and deliveries.
    modport master (
        output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        output mapped_stall,
        input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
        input  mapped_data_valid, mapped_data, mapped_address, fifo_overflow
    );

    // Bridge side.
    modport slave (
        input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        input  mapped_stall,
        output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data,
        output mapped_data_valid, mapped_data, mapped_address, fifo_overflow
    );
endinterface

// File: rtl/mmio_map_bridge.sv
// mmio_map_bridge: decodes host MMIO, answers DFH/AFU-ID/status reads, queues
// user-range writes in a FIFO and drains them onto the FPU mapped-data port.
// Optional feature: define MMIO_WR_COUNT_EN to add a 32-bit accepted-push
// counter readable (and clearable by write) at STAT_ADDR+2.
module mmio_map_bridge #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [15:0] USER_BASE = 16'h0020,
    parameter logic [15:0] STAT_ADDR = 16'h0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          afu_id,
    mmio_map_bridge_if.slave      bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam logic [15:0] CNT_ADDR = STAT_ADDR + 16'd2;
    localparam logic [63:0] DFH_VAL  = 64'h1000_0100_0000_0000;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          push_req_c;
    logic          stat_clr_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;
    logic          ovf_set_c;
    logic [63:0]   rd_data_c;

`ifdef MMIO_WR_COUNT_EN
    logic [31:0]   wr_cnt;
    logic          cnt_clr_c;
`endif

    // Write decode and FIFO push/pop qualification.
    always_comb begin
        push_req_c = bus.mmio_wr_valid && (bus.mmio_wr_addr >= USER_BASE);
        stat_clr_c = bus.mmio_wr_valid && (bus.mmio_wr_addr == STAT_ADDR);
        full_c     = (count == CW'(DEPTH));
        pop_c      = (count != '0) && !bus.mapped_stall;
        // A full FIFO still accepts a push when an entry leaves in the same cycle.
        push_c     = push_req_c && (!full_c || pop_c);
        ovf_set_c  = push_req_c && full_c && !pop_c;
    end

`ifdef MMIO_WR_COUNT_EN
    // Counter clear strobe.
    always_comb begin
        cnt_clr_c = bus.mmio_wr_valid && (bus.mmio_wr_addr == CNT_ADDR);
    end
`endif

    // Read data mux; status reflects pre-update count and overflow.
    always_comb begin
        rd_data_c = '0;
        case (bus.mmio_rd_addr)
            16'h0000:  rd_data_c = DFH_VAL;
            16'h0002:  rd_data_c = afu_id[63:0];
            16'h0004:  rd_data_c = afu_id[127:64];
            STAT_ADDR: rd_data_c = {overflow, 47'b0, 16'(count)};
`ifdef MMIO_WR_COUNT_EN
            CNT_ADDR:  rd_data_c = {32'b0, wr_cnt};
`endif
            default:   rd_data_c = '0;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{addr: bus.mmio_wr_addr, data: bus.mmio_wr_data[31:0]};
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_c) - CW'(pop_c);
            if (ovf_set_c)       overflow <= 1'b1;
            else if (stat_clr_c) overflow <= 1'b0;
        end
    end

`ifdef MMIO_WR_COUNT_EN
    // Accepted-push counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            wr_cnt <= '0;
        else if (cnt_clr_c) wr_cnt <= '0;
        else if (push_c)    wr_cnt <= wr_cnt + 32'd1;
    end
`endif

    // Registered FPU delivery: one pulse per popped entry, data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mapped_data_valid <= 1'b0;
            bus.mapped_data       <= '0;
            bus.mapped_address    <= '0;
        end else begin
            bus.mapped_data_valid <= pop_c;
            if (pop_c) begin
                bus.mapped_data    <= mem[rd_ptr].data;
                bus.mapped_address <= {16'b0, mem[rd_ptr].addr};
            end
        end
    end

    // Registered MMIO read response with echoed tid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mmio_rsp_valid <= 1'b0;
            bus.mmio_rsp_tid   <= '0;
            bus.mmio_rsp_data  <= '0;
        end else begin
            bus.mmio_rsp_valid <= bus.mmio_rd_valid;
            if (bus.mmio_rd_valid) begin
                bus.mmio_rsp_tid  <= bus.mmio_rd_tid;
                bus.mmio_rsp_data <= rd_data_c;
            end
        end
    end

    assign bus.fifo_overflow = overflow;
endmodule

// File: tb/tb_mmio_map_bridge.sv
// Self-checking bench for mmio_map_bridge: fixed vector table, directed FIFO
// corner sequences and random traffic against a queue-based reference model.
module tb_mmio_map_bridge;
    localparam int unsigned DEPTH     = 16;
    localparam logic [15:0] USER_BASE = 16'h0020;
    localparam logic [15:0] STAT_ADDR = 16'h0010;
    localparam logic [15:0] CNT_ADDR  = 16'h0012;
    localparam logic [63:0] DFH_VAL   = 64'h1000_0100_0000_0000;
    localparam logic [127:0] AFU_ID   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] afu_id = AFU_ID;

    mmio_map_bridge_if bus ();

    mmio_map_bridge dut (
        .clk    (clk),
        .rst    (rst),
        .afu_id (afu_id),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [47:0] q[$];
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic        e_pv;
    logic [31:0] e_md;
    logic [31:0] e_ma;
    logic        e_rv;
    logic [8:0]  e_tid;
    logic [63:0] e_rd;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
        e_pv  = 1'b0;
        e_md  = '0;
        e_ma  = '0;
        e_rv  = 1'b0;
        e_tid = '0;
        e_rd  = '0;
    endtask

    // Drive one cycle of inputs, predict from the model, check after the edge.
    task automatic step(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                        input logic rv, input logic [15:0] ra, input logic [8:0] tid,
                        input logic st);
        logic [63:0] rdata;
        logic [47:0] ent;
        logic        set_ovf;
        bus.mmio_wr_valid = wv;
        bus.mmio_wr_addr  = wa;
        bus.mmio_wr_data  = wd;
        bus.mmio_rd_valid = rv;
        bus.mmio_rd_addr  = ra;
        bus.mmio_rd_tid   = tid;
        bus.mapped_stall  = st;

        rdata = '0;
        if (ra == 16'h0000)      rdata = DFH_VAL;
        else if (ra == 16'h0002) rdata = AFU_ID[63:0];
        else if (ra == 16'h0004) rdata = AFU_ID[127:64];
        else if (ra == STAT_ADDR) rdata = {m_ovf, 47'b0, 16'(q.size())};
`ifdef MMIO_WR_COUNT_EN
        else if (ra == CNT_ADDR) rdata = {32'b0, m_cnt};
`endif
        e_rv = rv;
        if (rv) begin
            e_tid = tid;
            e_rd  = rdata;
        end

        e_pv = 1'b0;
        if (q.size() != 0 && !st) begin
            ent  = q.pop_front();
            e_pv = 1'b1;
            e_md = ent[31:0];
            e_ma = {16'b0, ent[47:32]};
        end

        set_ovf = 1'b0;
        if (wv && wa >= USER_BASE) begin
            if (q.size() < DEPTH) begin
                q.push_back({wa, wd[31:0]});
                m_cnt = m_cnt + 32'd1;
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (wv && wa == STAT_ADDR) m_ovf = 1'b0;
`ifdef MMIO_WR_COUNT_EN
        if (wv && wa == CNT_ADDR) m_cnt = '0;
`endif

        @(posedge clk);
        #1;
        chk("mapped_data_valid", 128'(bus.mapped_data_valid), 128'(e_pv));
        chk("mapped_data", 128'(bus.mapped_data), 128'(e_md));
        chk("mapped_address", 128'(bus.mapped_address), 128'(e_ma));
        chk("fifo_overflow", 128'(bus.fifo_overflow), 128'(m_ovf));
        chk("mmio_rsp_valid", 128'(bus.mmio_rsp_valid), 128'(e_rv));
        if (e_rv) begin
            chk("mmio_rsp_tid", 128'(bus.mmio_rsp_tid), 128'(e_tid));
            chk("mmio_rsp_data", 128'(bus.mmio_rsp_data), 128'(e_rd));
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 9'h0, st);
    endtask

    task automatic do_reset();
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mapped_stall  = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst mapped_data_valid", 128'(bus.mapped_data_valid), 128'(0));
        chk("rst mapped_data", 128'(bus.mapped_data), 128'(0));
        chk("rst mapped_address", 128'(bus.mapped_address), 128'(0));
        chk("rst rsp_valid", 128'(bus.mmio_rsp_valid), 128'(0));
        chk("rst rsp_data", 128'(bus.mmio_rsp_data), 128'(0));
        chk("rst fifo_overflow", 128'(bus.fifo_overflow), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        wv;
        logic [15:0] wa;
        logic [63:0] wd;
        logic        rv;
        logic [15:0] ra;
        logic [8:0]  tid;
        logic        st;
        logic        x_rv;
        logic [8:0]  x_tid;
        logic [63:0] x_rd;
        logic        x_pv;
        logic [31:0] x_md;
        logic [31:0] x_ma;
    } vec_t;

    function automatic vec_t mk(logic wv, logic [15:0] wa, logic [63:0] wd, logic rv,
                                logic [15:0] ra, logic [8:0] tid, logic st, logic x_rv,
                                logic [8:0] x_tid, logic [63:0] x_rd, logic x_pv,
                                logic [31:0] x_md, logic [31:0] x_ma);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.tid = tid; v.st = st;
        v.x_rv = x_rv; v.x_tid = x_tid; v.x_rd = x_rd; v.x_pv = x_pv; v.x_md = x_md; v.x_ma = x_ma;
        return v;
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0002;
            2:       return 16'h0004;
            3:       return STAT_ADDR;
            4:       return CNT_ADDR;
            5:       return 16'h0008;
            default: return USER_BASE + 16'($urandom_range(0, 255));
        endcase
    endfunction

    vec_t vt[13];
    int   k;
    logic [63:0] exp_cnt;

    initial begin
        // Fresh FIFO after reset; pulse shows at the check following the cycle after the write.
        vt[0]  = mk(0, 16'h0,  64'h0,            1, 16'h0000, 9'd1,  0, 1, 9'd1,  DFH_VAL,          0, 32'h0,        32'h0);
        vt[1]  = mk(0, 16'h0,  64'h0,            1, 16'h0002, 9'd2,  0, 1, 9'd2,  AFU_ID[63:0],     0, 32'h0,        32'h0);
        vt[2]  = mk(0, 16'h0,  64'h0,            1, 16'h0004, 9'd3,  0, 1, 9'd3,  AFU_ID[127:64],   0, 32'h0,        32'h0);
        vt[3]  = mk(1, 16'h20, 64'hAA_DEADBEEF,  0, 16'h0,    9'd0,  0, 0, 9'd0,  64'h0,            0, 32'h0,        32'h0);
        vt[4]  = mk(0, 16'h0,  64'h0,            0, 16'h0,    9'd0,  0, 0, 9'd0,  64'h0,            1, 32'hDEADBEEF, 32'h20);
        vt[5]  = mk(0, 16'h0,  64'h0,            0, 16'h0,    9'd0,  0, 0, 9'd0,  64'h0,            0, 32'hDEADBEEF, 32'h20);
        vt[6]  = mk(0, 16'h0,  64'h0,            1, 16'h0010, 9'd7,  0, 1, 9'd7,  64'h0,            0, 32'hDEADBEEF, 32'h20);
        vt[7]  = mk(0, 16'h0,  64'h0,            1, 16'h0006, 9'd8,  0, 1, 9'd8,  64'h0,            0, 32'hDEADBEEF, 32'h20);
        vt[8]  = mk(1, 16'h8,  64'h55,           1, 16'h0010, 9'd9,  0, 1, 9'd9,  64'h0,            0, 32'hDEADBEEF, 32'h20);
        vt[9]  = mk(1, 16'h21, 64'h1234_5678,    1, 16'h0010, 9'd10, 0, 1, 9'd10, 64'h0,            0, 32'hDEADBEEF, 32'h20);
        vt[10] = mk(0, 16'h0,  64'h0,            1, 16'h0010, 9'd11, 1, 1, 9'd11, 64'h1,            0, 32'hDEADBEEF, 32'h20);
        vt[11] = mk(0, 16'h0,  64'h0,            0, 16'h0,    9'd0,  0, 0, 9'd0,  64'h0,            1, 32'h1234_5678, 32'h21);
        vt[12] = mk(0, 16'h0,  64'h0,            1, 16'h0010, 9'd12, 0, 1, 9'd12, 64'h0,            0, 32'h1234_5678, 32'h21);

        bus.mmio_wr_valid = 1'b0;
        bus.mmio_wr_addr  = '0;
        bus.mmio_wr_data  = '0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_rd_addr  = '0;
        bus.mmio_rd_tid   = '0;
        bus.mapped_stall  = 1'b0;
        model_reset();
        #3;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra, vt[i].tid, vt[i].st);
            chk($sformatf("vec%0d rsp_valid", i), 128'(bus.mmio_rsp_valid), 128'(vt[i].x_rv));
            if (vt[i].x_rv) begin
                chk($sformatf("vec%0d rsp_tid", i), 128'(bus.mmio_rsp_tid), 128'(vt[i].x_tid));
                chk($sformatf("vec%0d rsp_data", i), 128'(bus.mmio_rsp_data), 128'(vt[i].x_rd));
            end
            chk($sformatf("vec%0d pulse", i), 128'(bus.mapped_data_valid), 128'(vt[i].x_pv));
            chk($sformatf("vec%0d mdata", i), 128'(bus.mapped_data), 128'(vt[i].x_md));
            chk($sformatf("vec%0d maddr", i), 128'(bus.mapped_address), 128'(vt[i].x_ma));
        end

        // Overfill under stall, then drain in order.
        for (int i = 0; i < 17; i++)
            step(1'b1, 16'(USER_BASE + 16'(i)), 64'(100 + i), 1'b0, 16'h0, 9'h0, 1'b1);
        step(1'b0, 16'h0, 64'h0, 1'b1, STAT_ADDR, 9'd20, 1'b1);
        chk("full status", 128'(bus.mmio_rsp_data), 128'({1'b1, 47'b0, 16'd16}));
        k = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1'b0);
            if (bus.mapped_data_valid) begin
                chk("drain order", 128'(bus.mapped_data), 128'(100 + k));
                k++;
            end
        end
        chk("drain pulse count", 128'(k), 128'(16));

        // Full FIFO with stall released and a write in the same cycle.
        step(1'b1, STAT_ADDR, 64'hFFFF, 1'b0, 16'h0, 9'h0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b1, 16'h0030, 64'(200 + i), 1'b0, 16'h0, 9'h0, 1'b1);
        step(1'b1, 16'h0031, 64'h777, 1'b0, 16'h0, 9'h0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, STAT_ADDR, 9'd21, 1'b1);
        chk("full pop+push status", 128'(bus.mmio_rsp_data), 128'({1'b0, 47'b0, 16'd16}));

        // Drop sets overflow; draining then clearing returns status 0.
        step(1'b1, 16'h0032, 64'h888, 1'b0, 16'h0, 9'h0, 1'b1);
        chk("overflow after drop", 128'(bus.fifo_overflow), 128'(1));
        for (int i = 0; i < 18; i++) idle(1'b0);
        step(1'b1, STAT_ADDR, 64'h0, 1'b0, 16'h0, 9'h0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, STAT_ADDR, 9'd22, 1'b0);
        chk("status after clear", 128'(bus.mmio_rsp_data), 128'(0));

        // Reset with entries queued discards them.
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h0040, 64'(300 + i), 1'b0, 16'h0, 9'h0, 1'b1);
        do_reset();
        k = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b0);
            if (bus.mapped_data_valid) k++;
        end
        chk("pulses after reset", 128'(k), 128'(0));
        step(1'b0, 16'h0, 64'h0, 1'b1, STAT_ADDR, 9'd23, 1'b0);
        chk("status after reset", 128'(bus.mmio_rsp_data), 128'(0));

        // Accepted-push counter.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h0040, 64'(i), 1'b0, 16'h0, 9'h0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, CNT_ADDR, 9'd24, 1'b0);
`ifdef MMIO_WR_COUNT_EN
        exp_cnt = 64'd3;
`else
        exp_cnt = 64'd0;
`endif
        chk("push counter", 128'(bus.mmio_rsp_data), 128'(exp_cnt));
        step(1'b1, CNT_ADDR, 64'h0, 1'b0, 16'h0, 9'h0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, CNT_ADDR, 9'd25, 1'b0);
        chk("push counter cleared", 128'(bus.mmio_rsp_data), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), rand_addr(), 9'($urandom_range(0, 511)),
                 1'($urandom_range(0, 99) < 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
